// File: rtl/ahb_simple_pair.sv
// ahb_simple_pair: AHB-Lite smoke subsystem, one master writing/reading back a burst to one memory slave
//   HCLK/HRESETn    clock, synchronous active-low reset
//   start           1-cycle run request, accepted in IDLE or DONE
//   done, pass      run finished / read-back matched (pass valid while done)
//   HADDR..HREADYOUT internal bus brought out for observation
//   cycle_cnt       busy-cycle counter, present only with AHB_PERF_CNT_EN defined
`timescale 1ns/1ps
module ahb_simple_pair #(
    parameter int NUM_XFERS   = 4,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    output logic        done,
    output logic        pass,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HSEL,
    output logic        HREADY,
`ifdef AHB_PERF_CNT_EN
    output logic [15:0] cycle_cnt,
`endif
    output logic        HREADYOUT
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam int IW = NUM_XFERS > 1 ? $clog2(NUM_XFERS) : 1;
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] i;
    logic accept, last, xfer_done;
    logic dp, dp_wr, dp_inr;
    logic [AW-1:0] dp_idx;
    logic [2:0] wc;
    logic [31:0] mem [MEM_DEPTH];
    assign accept    = (state == IDLE || state == DONE) && start;
    assign last      = i == IW'(NUM_XFERS - 1);
    assign xfer_done = (state == WR_DATA || state == RD_DATA) && HREADY;
    assign HSEL      = state == WR_ADDR || state == RD_ADDR;
    assign HWRITE    = state == WR_ADDR || state == WR_DATA;
    assign HADDR     = 32'(i) << 2;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? WR_ADDR : state;
            WR_ADDR:    state_nxt = WR_DATA;
            WR_DATA:    state_nxt = !HREADY ? WR_DATA : last ? RD_ADDR : WR_ADDR;
            RD_ADDR:    state_nxt = RD_DATA;
            RD_DATA:    state_nxt = !HREADY ? RD_DATA : last ? DONE : RD_ADDR;
            default:    state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state  <= IDLE;
            i      <= '0;
            pass   <= 1'b0;
            done   <= 1'b0;
            HWDATA <= '0;
        end else begin
            state <= state_nxt;
            done  <= state_nxt == DONE;
            if (accept)
                i <= '0;
            else if (xfer_done)
                i <= last ? '0 : i + 1'b1;
            if (state == WR_ADDR)
                HWDATA <= 32'hA5A5_0000 + 32'(i);
            if (accept)
                pass <= 1'b1;
            else if (state == RD_DATA && HREADY && HRDATA != 32'hA5A5_0000 + 32'(i))
                pass <= 1'b0;
        end
    end
    // Slave: a data phase is live from the address-phase edge until the first HREADYOUT=1 cycle.
    assign HREADYOUT = !dp || wc == 3'd0;
    assign HREADY    = HREADYOUT;
    assign HRDATA    = (dp && !dp_wr) ? (dp_inr ? mem[dp_idx] : 32'hDEAD_BEEF) : 32'h0;
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp     <= 1'b0;
            dp_wr  <= 1'b0;
            dp_inr <= 1'b0;
            dp_idx <= '0;
            wc     <= '0;
            for (int k = 0; k < MEM_DEPTH; k++)
                mem[k] <= '0;
        end else begin
            if (dp && HREADYOUT && dp_wr && dp_inr)
                mem[dp_idx] <= HWDATA;
            if (HSEL && HREADY) begin
                dp     <= 1'b1;
                dp_wr  <= HWRITE;
                dp_inr <= HADDR < 32'(4 * MEM_DEPTH);
                dp_idx <= HADDR[AW+1:2];
                wc     <= 3'(WAIT_STATES);
            end else if (HREADYOUT)
                dp <= 1'b0;
            else
                wc <= wc - 3'd1;
        end
    end
`ifdef AHB_PERF_CNT_EN
    always_ff @(posedge HCLK) begin
        if (!HRESETn || accept)
            cycle_cnt <= '0;
        else if (state != IDLE && state != DONE && cycle_cnt != 16'hFFFF)
            cycle_cnt <= cycle_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ahb_simple_pair.sv
// tb_ahb_simple_pair: self-checking bench for ahb_simple_pair (one-wait-state and zero-wait-state instances)
`timescale 1ns/1ps
module tb_ahb_simple_pair;
    localparam int WS = 1;
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } xfer_t;
    typedef struct { int corrupt_at; int restart_at; logic exp_pass; int exp_cyc; } row_t;
    logic hclk = 1'b0, hresetn = 1'b0, start = 1'b0;
    logic done, pass, hwrite, hsel, hready, hreadyout;
    logic [31:0] haddr, hwdata, hrdata;
    logic done0, pass0, hwrite0, hsel0, hready0, hreadyout0;
    logic [31:0] haddr0, hwdata0, hrdata0;
`ifdef AHB_PERF_CNT_EN
    logic [15:0] cycle_cnt, cycle_cnt0;
`endif
    xfer_t sb[$];
    xfer_t cur;
    int tests = 0, fails = 0, nsel = 0, low0 = 0, ws = 0;
    bit in_dp = 1'b0, mon_en = 1'b0;
    always #5 hclk = ~hclk;
    ahb_simple_pair #(.NUM_XFERS(4), .MEM_DEPTH(16), .WAIT_STATES(WS)) dut (
        .HCLK(hclk), .HRESETn(hresetn), .start(start), .done(done), .pass(pass),
        .HADDR(haddr), .HWRITE(hwrite), .HWDATA(hwdata), .HRDATA(hrdata),
        .HSEL(hsel), .HREADY(hready),
`ifdef AHB_PERF_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .HREADYOUT(hreadyout));
    ahb_simple_pair #(.NUM_XFERS(4), .MEM_DEPTH(16), .WAIT_STATES(0)) dut0 (
        .HCLK(hclk), .HRESETn(hresetn), .start(start), .done(done0), .pass(pass0),
        .HADDR(haddr0), .HWRITE(hwrite0), .HWDATA(hwdata0), .HRDATA(hrdata0),
        .HSEL(hsel0), .HREADY(hready0),
`ifdef AHB_PERF_CNT_EN
        .cycle_cnt(cycle_cnt0),
`endif
        .HREADYOUT(hreadyout0));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic mon();
        if (!mon_en) begin
            in_dp = 1'b0;
            return;
        end
        if (!hreadyout0) low0++;
        if (hsel) begin
            nsel++;
            if (sb.size() == 0)
                chk("sb_unexpected_addr_phase", haddr, 32'hFFFF_FFFF);
            else begin
                cur = sb.pop_front();
                chk("haddr", haddr, cur.addr);
                chk("hwrite", {31'd0, hwrite}, {31'd0, cur.wr});
                in_dp = 1'b1;
                ws = 0;
            end
        end else if (in_dp) begin
            if (!hready)
                ws++;
            else begin
                chk(cur.wr ? "hwdata" : "hrdata", cur.wr ? hwdata : hrdata, cur.data);
                chk("wait_states", ws, WS);
                in_dp = 1'b0;
            end
        end
    endtask
    task automatic tick();
        @(posedge hclk);
        #1;
        mon();
    endtask
    task automatic push_seq(input int zero_word);
        for (int k = 0; k < 4; k++)
            sb.push_back('{1'b1, 32'(4 * k), 32'hA5A5_0000 + 32'(k)});
        for (int k = 0; k < 4; k++)
            sb.push_back('{1'b0, 32'(4 * k), k == zero_word ? 32'h0 : 32'hA5A5_0000 + 32'(k)});
    endtask
    task automatic chk_reset();
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_hwrite", {31'd0, hwrite}, 32'h0);
        chk("rst_hsel", {31'd0, hsel}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        chk("rst_pass", {31'd0, pass}, 32'h0);
        chk("rst_hreadyout", {31'd0, hreadyout}, 32'h1);
        chk("rst0_data", haddr0 | hwdata0 | hrdata0, 32'h0);
        chk("rst0_ctl", {27'd0, hwrite0, hsel0, done0, pass0, hready0}, 32'h1);
`ifdef AHB_PERF_CNT_EN
        chk("rst_cycle_cnt", {16'd0, cycle_cnt}, 32'h0);
`endif
    endtask
    task automatic run_row(input row_t r);
        int c = 0, c0 = -1, c1 = -1;
        push_seq(r.corrupt_at >= 0 ? 2 : -1);
        nsel = 0;
        low0 = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while ((c0 < 0 || c1 < 0) && c < 200) begin
            if (c == r.restart_at) start = 1'b1;
            tick();
            start = 1'b0;
            c++;
            if (c == r.corrupt_at) dut.mem[2] = 32'h0;
            if (done0 && c0 < 0) c0 = c;
            if (done && c1 < 0) c1 = c;
        end
        chk("done_cycles", c1, r.exp_cyc);
        chk("done_cycles_ws0", c0, 16);
        chk("pass", {31'd0, pass}, {31'd0, r.exp_pass});
        chk("pass_ws0", {31'd0, pass0}, 32'h1);
        chk("addr_phases", nsel, 8);
        chk("sb_left", sb.size(), 0);
        chk("hreadyout_low_ws0", low0, 0);
`ifdef AHB_PERF_CNT_EN
        chk("cycle_cnt", {16'd0, cycle_cnt}, 32'd24);
        chk("cycle_cnt_ws0", {16'd0, cycle_cnt0}, 32'd16);
`endif
        sb.delete();
    endtask
    initial begin
        row_t rows[3];
        rows[0] = '{-1, -1, 1'b1, 24};
        rows[1] = '{12, -1, 1'b0, 24};
        rows[2] = '{-1, 5, 1'b1, 24};
        tick();
        tick();
        hresetn = 1'b1;
        tick();
        chk_reset();
        mon_en = 1'b1;
        for (int n = 0; n < 3; n++)
            run_row(rows[n]);
        push_seq(-1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++)
            tick();
        mon_en = 1'b0;
        hresetn = 1'b0;
        tick();
        chk_reset();
        hresetn = 1'b1;
        sb.delete();
        mon_en = 1'b1;
        run_row(rows[0]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ahb_simple_pair.md
Name: ahb_simple_pair

Overview:
Self-contained AHB-Lite-style test subsystem with one bus master and one memory slave.
- On a start pulse, the master issues a fixed burst of single writes, then single reads back to the same addresses, and checks the read data.
- The internal bus signals are brought out to ports for waveform and assertion visibility.
- Used as a bus-protocol smoke block and as a reference transaction generator.

Parameters:
- NUM_XFERS, 4: writes issued per run; the same number of reads follows. Range 1..MEM_DEPTH.
- MEM_DEPTH, 16: slave memory depth in 32-bit words. Power of two.
- WAIT_STATES, 1: number of HREADYOUT-low cycles the slave inserts in every data phase. Range 0..7.

Ports:
- HCLK  in  1  single clock; all logic on the rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- start  in  1  1-cycle request to run the sequence; ignored unless the master is IDLE or DONE.
- done  out  1  high in DONE state, held until the next accepted start.
- pass  out  1  result of the read-back compare; valid while done=1.
- HADDR  out  32  transfer address; byte address, word aligned.
- HWRITE  out  1  1 = write, 0 = read.
- HWDATA  out  32  write data, driven in the data phase.
- HRDATA  out  32  slave read data.
- HSEL  out  1  slave select; high only in an address-phase cycle.
- HREADY  out  1  bus ready; equals HREADYOUT (single slave).
- HREADYOUT  out  1  slave ready.

Behaviour:
Reset (HRESETn=0 at an edge):
- HADDR, HWDATA, HRDATA = 0; HWRITE, HSEL, done, pass = 0; HREADYOUT = 1.
- Slave memory cleared to 0; master FSM returns to IDLE.
- A reset mid-sequence aborts the sequence, with no partial completion.

Master FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE.
- IDLE/DONE to WR_ADDR on start. Entering WR_ADDR sets pass=1, clears done and sets index i=0.
- WR_ADDR (1 cycle): HSEL=1, HWRITE=1, HADDR=4*i. Then go to WR_DATA.
- WR_DATA: HSEL=0; HADDR and HWRITE held; HWDATA = 32'hA5A5_0000 + i.
  - Stays until HREADY=1.
  - Then i++; go to WR_ADDR if i<NUM_XFERS, else i=0 and go to RD_ADDR.
- RD_ADDR / RD_DATA: the same pattern with HWRITE=0.
  - In the RD_DATA cycle with HREADY=1, compare HRDATA against 32'hA5A5_0000 + i; on mismatch, pass=0.
  - After the last read, go to DONE.
- Transfers are non-pipelined. Each transfer takes exactly 2+WAIT_STATES cycles, with no idle cycles between transfers.
- HWDATA holds its last value outside WR_DATA.

Slave:
- Address phase is the cycle with HSEL=1 and HREADY=1. In it the slave latches the word index HADDR[log2(MEM_DEPTH)+1:2], HWRITE, and an in-range flag (HADDR < 4*MEM_DEPTH).
- In the following data phase, HREADYOUT=0 for WAIT_STATES cycles, then 1 for one cycle. HREADYOUT=1 whenever no data phase is active.
- Write: the memory word updates from HWDATA at the edge ending the data-phase cycle with HREADYOUT=1. Out-of-range writes are dropped.
- Read: HRDATA is combinational.
  - During a read data phase: mem[index], or 32'hDEAD_BEEF when out of range.
  - Otherwise: 0.
- HRDATA must be valid whenever HREADYOUT=1 in a read data phase, including when WAIT_STATES=0.
- start during a run is ignored. start in DONE restarts the sequence; memory is not cleared on restart.

Optional Feature:
AHB_PERF_CNT_EN:
- Defined: adds output cycle_cnt (16 bits).
  - Resets to 0; cleared when start is accepted.
  - Increments every cycle the FSM is outside IDLE and DONE.
  - Holds its value in DONE; saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset held for 2 cycles, then released -> all outputs at reset values, HREADYOUT=1, done=0.
- Defaults, start pulse -> writes A5A50000..A5A50003 to HADDR 0,4,8,C, then four reads return the same data. done=1 and pass=1 after 24 cycles; with AHB_PERF_CNT_EN, cycle_cnt=24.
- WAIT_STATES=0 -> each transfer takes 2 cycles, HREADYOUT never low, done after 16 cycles, pass=1.
- Force memory word 2 to 0 after the write phase -> the read at 0x8 returns 0, pass=0 at done.
- Assert HRESETn=0 during the third write -> next cycle shows IDLE with outputs at reset values; a new start completes with pass=1.
- start pulsed again mid-run -> ignored; exactly 2*NUM_XFERS address phases (HSEL=1 cycles) are counted.
